alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, clocked successor to the team's combinational 32-bit ALU (num1/num2/cm in, num3/FL out).
- Width is generalised, operands are accepted through a valid/ready handshake, and results and flags are registered.
- Adds multi-cycle iterative multiply and unsigned divide/remainder.
- Sits between operand registers and the writeback stage of the datapath.

Parameters:
- WIDTH, 32: operand and result width in bits. Legal range 8..64.
- CNT_W, 7: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and opcode are presented.
- in_ready  out  1  block can accept an operation (high only in IDLE).
- cm  in  4  opcode.
- num1  in  WIDTH  operand A.
- num2  in  WIDTH  operand B.
- out_valid  out  1  one-cycle pulse; num3/FL are updated this cycle.
- num3  out  WIDTH  registered result.
- FL  out  4  registered flags {N,Z,C,V}.
- dz  out  1  registered divide-by-zero indicator.

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, num3=0, FL=0, dz=0, counter=0, internal accumulators=0. Reset asserted mid-operation discards that operation; no out_valid is produced for it.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready. cm, num1 and num2 are captured on that edge. Inputs are don't-care at all other times. in_valid while busy is ignored, not queued.
- States:
  - IDLE -> DONE on accepted single-cycle op. The result is computed on the accepting edge.
  - IDLE -> MUL on cm=9.
  - IDLE -> DIV on cm=10 or 11.
  - MUL/DIV -> DONE after exactly WIDTH iteration cycles.
  - DONE -> IDLE unconditionally. out_valid=1 during DONE.
- Latency (accept edge = k):
  - Single-cycle op: out_valid is high in the cycle after edge k, num3/FL valid then.
  - MUL/DIV: out_valid is high in the cycle after edge k+WIDTH.
  - Throughput: single-cycle ops 1 per 2 cycles; MUL/DIV 1 per WIDTH+2 cycles.
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLL: A<<B[log2 WIDTH-1:0].
  - 6 SRL: logical right shift, same shift-amount field.
  - 7 SRA: arithmetic right shift, same shift-amount field.
  - 8 SLT: signed compare, result 1 or 0.
  - 9 MUL: low WIDTH bits of A*B, shift-add, one bit per cycle.
  - 10 DIVU: unsigned quotient, restoring divide, one bit per cycle.
  - 11 REMU: unsigned remainder, same divider.
  - 12 PASSA: num3=A.
  - 13-15: reserved. num3=0, FL=0, single-cycle.
- Flags, registered with num3:
  - N = num3[WIDTH-1]; Z = (num3==0).
  - C:
    - ADD: carry out.
    - SUB: 1 means no borrow (A>=B unsigned).
    - Shifts: last bit shifted out, 0 if shift amount is 0.
    - All other ops: 0.
  - V:
    - ADD/SUB: signed overflow.
    - MUL: 1 if the high WIDTH bits of the full product are nonzero.
    - All other ops: 0.
- Divide by zero (B=0): takes the full WIDTH cycles. DIVU num3 = all ones; REMU num3 = A. dz=1. dz=0 for every other completed op.
- Output hold: num3/FL/dz hold their value until the next DONE; they do not change on accept.

Test Plan:
- WIDTH=32, ADD num1=0x11, num2=0x101 -> out_valid one cycle after accept; num3=0x112, FL=0000. SUB on the same operands -> num3=0xFFFFFF10, N=1, Z=0, C=0, V=0.
- ADD 0x7FFFFFFF+0x1 -> num3=0x80000000, FL N=1, V=1, C=0. ADD 0xFFFFFFFF+0x1 -> num3=0, Z=1, C=1.
- MUL 0x11*0x101 -> in_ready low for 33 cycles, out_valid 33 cycles after the accept edge, num3=0x1111, V=0. MUL 0x10000*0x10000 -> num3=0, Z=1, V=1.
- DIVU 0x101/0x11 -> num3=0xF; REMU -> num3=0x2. DIVU by 0 with A=0x55 -> num3=0xFFFFFFFF, dz=1; REMU by 0 -> num3=0x55, dz=1.
- Handshake: hold in_valid high with a new op during a MUL -> ignored until IDLE, then accepted. Back-to-back ADDs -> in_ready alternates 1/0.
- Assert rst 5 cycles into a DIVU -> immediately num3=0, FL=0, in_ready=1, no out_valid. A subsequent AND 0xF0F0&0xFF00 -> num3=0xF000.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready operand handshake and registered result and flags.
// Single-cycle ops finish on the accept edge. MUL and DIVU/REMU iterate one bit per cycle.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cm,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             out_valid,
  output logic [WIDTH-1:0] num3,
  output logic [3:0]       FL,
  output logic             dz
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;
  localparam logic [3:0] OP_DIVU  = 4'd10;
  localparam logic [3:0] OP_REMU  = 4'd11;
  localparam logic [3:0] OP_PASSA = 4'd12;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;    // MUL: partial product high half; DIV: remainder
  logic [WIDTH-1:0] lo_q, lo_d;    // MUL: multiplier / product low half; DIV: dividend / quotient
  logic [WIDTH-1:0] opb_q, opb_d;  // MUL: multiplicand; DIV: divisor
  logic             rem_q, rem_d;
  logic [WIDTH-1:0] num3_q, num3_d;
  logic [3:0]       fl_q, fl_d;
  logic             dz_q, dz_d;

  logic [SH_W-1:0]         shamt;
  logic [WIDTH:0]          add_w, sub_w, sll_w, srl_w;
  logic signed [WIDTH:0]   sra_w;
  logic [WIDTH-1:0]        alu_res;
  logic                    alu_c, alu_v, alu_rsvd;
  logic [3:0]              alu_fl;

  logic [WIDTH:0]          mul_sum;
  logic [WIDTH-1:0]        mul_lo_n;
  logic [WIDTH:0]          div_shift;
  logic                    div_ge;
  logic [WIDTH-1:0]        div_rem_n, div_quo_n;
  logic [WIDTH-1:0]        fin;
  logic                    last;

  assign shamt = num2[SH_W-1:0];

  always_comb begin
    add_w    = {1'b0, num1} + {1'b0, num2};
    sub_w    = {1'b0, num1} - {1'b0, num2};
    // Extra bit on each shifter catches the last bit shifted out (0 when shamt is 0).
    sll_w    = {1'b0, num1} << shamt;
    srl_w    = {num1, 1'b0} >> shamt;
    sra_w    = $signed({num1, 1'b0}) >>> shamt;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_rsvd = 1'b0;
    unique case (cm)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (num1[WIDTH-1] == num2[WIDTH-1]) && (add_w[WIDTH-1] != num1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = ~sub_w[WIDTH];
        alu_v   = (num1[WIDTH-1] != num2[WIDTH-1]) && (sub_w[WIDTH-1] != num1[WIDTH-1]);
      end
      OP_AND:   alu_res = num1 & num2;
      OP_OR:    alu_res = num1 | num2;
      OP_XOR:   alu_res = num1 ^ num2;
      OP_SLL: begin
        alu_res = sll_w[WIDTH-1:0];
        alu_c   = sll_w[WIDTH];
      end
      OP_SRL: begin
        alu_res = srl_w[WIDTH:1];
        alu_c   = srl_w[0];
      end
      OP_SRA: begin
        alu_res = sra_w[WIDTH:1];
        alu_c   = sra_w[0];
      end
      OP_SLT:   alu_res[0] = $signed(num1) < $signed(num2);
      OP_PASSA: alu_res = num1;
      default:  alu_rsvd = 1'b1;
    endcase
    alu_fl = alu_rsvd ? 4'b0000 : {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
  end

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_rem_n = div_ge ? WIDTH'(div_shift - {1'b0, opb_q}) : div_shift[WIDTH-1:0];
    div_quo_n = {lo_q[WIDTH-2:0], div_ge};
    last      = cnt_q == CNT_W'(WIDTH - 1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    num3_d  = num3_q;
    fl_d    = fl_q;
    dz_d    = dz_q;
    fin     = rem_q ? div_rem_n : div_quo_n;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cnt_d = '0;
          if (cm == OP_MUL) begin
            state_d = ST_MUL;
            hi_d    = '0;
            lo_d    = num2;
            opb_d   = num1;
          end else if (cm == OP_DIVU || cm == OP_REMU) begin
            state_d = ST_DIV;
            hi_d    = '0;
            lo_d    = num1;
            opb_d   = num2;
            rem_d   = cm == OP_REMU;
          end else begin
            state_d = ST_DONE;
            num3_d  = alu_res;
            fl_d    = alu_fl;
            dz_d    = 1'b0;
          end
        end
      end
      ST_MUL: begin
        hi_d  = mul_sum[WIDTH:1];
        lo_d  = mul_lo_n;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          state_d = ST_DONE;
          num3_d  = mul_lo_n;
          fl_d    = {mul_lo_n[WIDTH-1], mul_lo_n == '0, 1'b0, |mul_sum[WIDTH:1]};
          dz_d    = 1'b0;
        end
      end
      ST_DIV: begin
        hi_d  = div_rem_n;
        lo_d  = div_quo_n;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          // A zero divisor falls out of the restoring loop as all-ones quotient, remainder A.
          state_d = ST_DONE;
          num3_d  = fin;
          fl_d    = {fin[WIDTH-1], fin == '0, 2'b00};
          dz_d    = opb_q == '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      rem_q   <= 1'b0;
      num3_q  <= '0;
      fl_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      num3_q  <= num3_d;
      fl_q    <= fl_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = state_q == ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign num3      = num3_q;
  assign FL        = fl_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, handshake/reset sequences, and random ops
// compared against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    cm;
  logic [W-1:0]  num1, num2;
  logic          out_valid;
  logic [W-1:0]  num3;
  logic [3:0]    fl;
  logic          dz;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.WIDTH(W), .CNT_W(7)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cm       (cm),
    .num1     (num1),
    .num2     (num2),
    .out_valid(out_valid),
    .num3     (num3),
    .FL       (fl),
    .dz       (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   fl;
    logic         dz;
    int           lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Reference model straight from the opcode rules, using wide integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic [3:0] f, output logic d, output int lat);
    longint          sa, sb, s;
    longint unsigned ua, ub;
    logic   [63:0]   p;
    int              sh;
    logic            c, v;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    sh = int'(b[4:0]);
    r = '0; c = 1'b0; v = 1'b0; d = 1'b0; lat = 1;
    case (op)
      4'd0: begin
        r = a + b; c = (ua + ub) > 64'hFFFF_FFFF;
        s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        r = a - b; c = a >= b;
        s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin r = a << sh; c = (sh == 0) ? 1'b0 : a[W - sh]; end
      4'd6: begin r = a >> sh; c = (sh == 0) ? 1'b0 : a[sh - 1]; end
      4'd7: begin r = W'(sa >>> sh); c = (sh == 0) ? 1'b0 : a[sh - 1]; end
      4'd8: r = (sa < sb) ? 1 : 0;
      4'd9: begin
        p = ua * ub; r = p[31:0]; v = p[63:32] != 0; lat = W + 1;
      end
      4'd10: begin r = (b == 0) ? '1 : a / b; d = b == 0; lat = W + 1; end
      4'd11: begin r = (b == 0) ? a : a % b; d = b == 0; lat = W + 1; end
      4'd12: r = a;
      default: ;
    endcase
    if (op >= 4'd13) f = 4'b0000;
    else f = {r[W-1], r == '0, c, v};
  endfunction

  // Call just after a negedge; returns at the negedge where out_valid is seen.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic [3:0] f, output logic d,
                        output int lat);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_before_op", in_ready, 1);
    cm = op; num1 = a; num2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cm = 4'($urandom); num1 = $urandom; num2 = $urandom;
    lat = 0; r = '0; f = '0; d = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i; r = num3; f = fl; d = dz;
        break;
      end
    end
  endtask

  vec_t          vt[18];
  logic [W-1:0]  r, er, r1, r2;
  logic [3:0]    f, ef;
  logic          d, ed;
  int            lat, elat, n1, n2, lowcnt, ovcnt;
  logic [3:0]    op;
  logic [W-1:0]  a, b;

  initial begin
    vt[0]  = '{4'd0,  32'h11,         32'h101,      32'h112,        4'b0000, 1'b0, 1};
    vt[1]  = '{4'd1,  32'h11,         32'h101,      32'hFFFFFF10,   4'b1000, 1'b0, 1};
    vt[2]  = '{4'd0,  32'h7FFFFFFF,   32'h1,        32'h80000000,   4'b1001, 1'b0, 1};
    vt[3]  = '{4'd0,  32'hFFFFFFFF,   32'h1,        32'h0,          4'b0110, 1'b0, 1};
    vt[4]  = '{4'd9,  32'h11,         32'h101,      32'h1111,       4'b0000, 1'b0, 33};
    vt[5]  = '{4'd9,  32'h10000,      32'h10000,    32'h0,          4'b0101, 1'b0, 33};
    vt[6]  = '{4'd10, 32'h101,        32'h11,       32'hF,          4'b0000, 1'b0, 33};
    vt[7]  = '{4'd11, 32'h101,        32'h11,       32'h2,          4'b0000, 1'b0, 33};
    vt[8]  = '{4'd10, 32'h55,         32'h0,        32'hFFFFFFFF,   4'b1000, 1'b1, 33};
    vt[9]  = '{4'd11, 32'h55,         32'h0,        32'h55,         4'b0000, 1'b1, 33};
    vt[10] = '{4'd5,  32'h80000001,   32'h1,        32'h2,          4'b0010, 1'b0, 1};
    vt[11] = '{4'd7,  32'h80000000,   32'h4,        32'hF8000000,   4'b1000, 1'b0, 1};
    vt[12] = '{4'd6,  32'hF,          32'h4,        32'h0,          4'b0110, 1'b0, 1};
    vt[13] = '{4'd8,  32'hFFFFFFFF,   32'h1,        32'h1,          4'b0000, 1'b0, 1};
    vt[14] = '{4'd13, 32'h5,          32'h6,        32'h0,          4'b0000, 1'b0, 1};
    vt[15] = '{4'd12, 32'h0,          32'h1234,     32'h0,          4'b0100, 1'b0, 1};
    vt[16] = '{4'd5,  32'h1234,       32'h20,       32'h1234,       4'b0000, 1'b0, 1};
    vt[17] = '{4'd1,  32'h5,          32'h5,        32'h0,          4'b0110, 1'b0, 1};

    rst = 1'b1; in_valid = 1'b0; cm = '0; num1 = '0; num2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_num3", num3, 0);
    chk("rst_fl", fl, 0);
    chk("rst_dz", dz, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, r, f, d, lat);
      chk($sformatf("vec%0d_res", i), r, vt[i].res);
      chk($sformatf("vec%0d_fl", i), f, vt[i].fl);
      chk($sformatf("vec%0d_dz", i), d, vt[i].dz);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
    end

    // in_valid held high through a MUL with a different op: ignored until IDLE.
    @(negedge clk);
    cm = 4'd9; num1 = 32'h11; num2 = 32'h101; in_valid = 1'b1;
    @(posedge clk);
    #1;
    cm = 4'd0; num1 = 32'h3; num2 = 32'h4;
    lowcnt = 0; n1 = 0; n2 = 0; r1 = '0; r2 = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i <= 33 && !in_ready) lowcnt++;
      if (i == 34) chk("busy_ready_after_done", in_ready, 1);
      if (out_valid) begin
        if (n1 == 0) begin n1 = i; r1 = num3; end
        else begin n2 = i; r2 = num3; in_valid = 1'b0; break; end
      end
    end
    in_valid = 1'b0;
    chk("busy_ready_low_cycles", lowcnt, 33);
    chk("busy_mul_lat", n1, 33);
    chk("busy_mul_res", r1, 32'h1111);
    chk("busy_add_lat", n2, 35);
    chk("busy_add_res", r2, 32'h7);

    // Back-to-back ADDs: in_ready toggles every cycle.
    @(negedge clk);
    cm = 4'd0; num1 = 32'h1; num2 = 32'h2; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("b2b_ready%0d", i), in_ready, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("b2b_valid%0d", i), out_valid, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 1) chk($sformatf("b2b_res%0d", i), num3, 32'h3);
      if (i < 5) @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Reset five cycles into a DIVU discards it.
    run_op(4'd10, 32'h55, 32'h0, r, f, d, lat);
    chk("pre_rst_dz", d, 1);
    @(negedge clk);
    cm = 4'd10; num1 = 32'h101; num2 = 32'h11; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_num3", num3, 0);
    chk("midrst_fl", fl, 0);
    chk("midrst_dz", dz, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    ovcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) ovcnt++;
    end
    chk("midrst_no_out_valid", ovcnt, 0);
    run_op(4'd2, 32'hF0F0, 32'hFF00, r, f, d, lat);
    chk("post_rst_and_res", r, 32'hF000);
    chk("post_rst_and_fl", f, 4'b0000);
    chk("post_rst_and_lat", lat, 1);

    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
      model(op, a, b, er, ef, ed, elat);
      run_op(op, a, b, r, f, d, lat);
      chk($sformatf("rand%0d_op%0d_res", i, op), r, er);
      chk($sformatf("rand%0d_op%0d_fl", i, op), f, ef);
      chk($sformatf("rand%0d_op%0d_dz", i, op), d, ed);
      chk($sformatf("rand%0d_op%0d_lat", i, op), lat, elat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
